wdt_chain: RTL and testbench
============================

// Module: wdt_chain
// PURPOSE
//  Parametrised multi-stage watchdog for the SoC interface. NUM_TIMERS counters share a prescaled tick;
//  each is independent or cascaded behind its predecessor, forming chain segments. A timed-out segment
//  tail raises a sticky fatal. Adds window (early-restart) detection and a prescaler; feeds WDT status/intr.
// PARAMETERS
//  NUM_TIMERS  3   number of timers (2..8); timer 0 is always a segment head
//  CNT_W       64  counter/period width per timer
//  PRESCALE_W  8   prescaler divider width
// PORTS
//  clk                 in   1             clock
//  cptra_rst           in   1             reset, asynchronous, active-high
//  tmr_en              in   NUM_TIMERS    count enable, independent timers only
//  tmr_cascade         in   NUM_TIMERS    1: timer i cascaded behind i-1 (bit 0 ignored)
//  tmr_restart         in   NUM_TIMERS    software restart pulse (independent timers only)
//  tmr_period          in   NUM_TIMERS*CNT_W  timeout period, timer i at [i*CNT_W +: CNT_W]
//  tmr_window          in   NUM_TIMERS*CNT_W  minimum count before restart legal; 0 disables
//  prescale_div        in   PRESCALE_W    tick every prescale_div+1 cycles
//  tmr_serviced        in   NUM_TIMERS    timeout-serviced pulse from interrupt logic
//  tmr_count           out  NUM_TIMERS*CNT_W  current counts
//  tmr_timeout         out  NUM_TIMERS    timer i count == period i
//  tmr_early_restart   out  NUM_TIMERS    sticky: restart issued inside window
//  fatal_timeout       out  1             sticky: a cascaded segment tail timed out
// BEHAVIOUR
//  Reset: all counts, prescaler, tmr_early_restart, fatal_timeout = 0. Async assert, sync use on clk.
//  Prescaler: pre_cnt increments each cycle; tick when pre_cnt >= prescale_div, pre_cnt -> 0 same edge.
//   div=0 -> tick every cycle. Lowering div mid-count ticks on next cycle (>= compare).
//  tmr_timeout[i] = (count_i == period_i), combinational off registered count; period 0 = timed out at reset.
//  Segment: head h (h==0 or cascade[h]=0) plus following timers with cascade=1; tail = last of segment.
//  Activity: head active when tmr_en[h]; cascaded timer i active when tmr_timeout[i-1]=1 (tmr_en[i] ignored).
//  Per-timer next count, priority order, evaluated only when active:
//   1. head, restart=1, not timed out: count -> 0 (immediate, not tick-gated)
//   2. segment reset by qualified service: count -> 0
//   3. tick and not timed out: count +1 (wraps never; saturates at period)
//   4. else hold. Inactive timers hold count.
//  Restart on cascaded timer or on timed-out head: ignored, no flag.
//  Window: restart accepted at head with window!=0 and count < window -> count still cleared,
//   tmr_early_restart[h] set next edge, held until reset.
//  Service: tmr_serviced[h] & tmr_timeout[h] on a head qualifies iff segment tail not timed out;
//   qualified service clears every timer in the segment (even inactive cascaded ones) same edge.
//   Single-timer segment: head is its own tail, service always qualifies when timed out.
//   tmr_serviced on a cascaded timer: ignored. Service without timeout: ignored.
//  Fatal: fatal_timeout set one cycle after any multi-timer segment tail has tmr_timeout=1; sticky to reset.
//   After fatal, that segment ignores service/restart; only cptra_rst reinitialises.
//  Mode change mid-count (tmr_cascade toggled): counts retained; new segmentation applies next cycle.
//  Simultaneous restart and service on head timed-out: restart ignored, service applies.
// TESTING
//  N=3, div=0, all independent, en=111, period0=5: count0 hits 5 at cycle 5, timeout0=1, holds; serviced0 -> count0=0.
//  cascade=110, period={4,3,2}, en0=1: t0 out @2, t1 out @5, t2 out @9, fatal_timeout=1 @10; serviced0 then ignored.
//  Same chain, serviced0 one cycle after t0 timeout: counts 0/1/2 -> 0/0/0, t1 not yet active, no fatal.
//  div=3, period0=2, en0=1: count0 increments every 4 cycles, timeout0 at cycle 8.
//  window0=10, restart0 at count0=4 -> count0=0, tmr_early_restart[0]=1 sticky; restart at 12 -> no flag change.
//  Assert cptra_rst mid-count with fatal set -> all counts, flags, fatal = 0 immediately (async).

Source files
------------

// File: rtl/wdt_chain.sv
// wdt_chain: multi-stage watchdog. NUM_TIMERS counters share one prescaled tick.
// Each counter is either a segment head, or it is cascaded behind its predecessor.
// A multi-timer segment whose tail times out raises a sticky fatal.
// Early restarts inside a head's window are latched as sticky flags.

// Per-timer counter: activity gating, restart/window handling, saturation at period.
module wdt_chain_tmr #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             cptra_rst,
   input  logic             tick,
   input  logic             is_head,
   input  logic             en,
   input  logic             prev_timeout,
   input  logic             restart,
   input  logic             seg_clr,
   input  logic             lock,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] window,
   output logic [CNT_W-1:0] count,
   output logic             timeout,
   output logic             early
);

   logic active;
   logic restart_ok;

   assign timeout    = (count == period);
   // heads follow software enable, cascaded timers run while the predecessor is timed out
   assign active     = is_head ? en : prev_timeout;
   // restart only means something on a live, not-yet-expired head of an unlocked segment
   assign restart_ok = is_head & active & restart & ~timeout & ~lock;

   // count: clear on accepted restart or segment service, else tick up to period and stick
   always_ff @(posedge clk or posedge cptra_rst) begin
      if (cptra_rst)
         count <= '0;
      else if (restart_ok | seg_clr)
         count <= '0;
      else if (active & tick & (count < period))
         count <= count + 1'b1;
   end

   // early-restart flag: a restart landing before the window opened, held until reset
   always_ff @(posedge clk or posedge cptra_rst) begin
      if (cptra_rst)
         early <= 1'b0;
      else if (restart_ok & (window != '0) & (count < window))
         early <= 1'b1;
   end

endmodule

module wdt_chain #(
   parameter int NUM_TIMERS = 3,
   parameter int CNT_W      = 64,
   parameter int PRESCALE_W = 8
) (
   input  logic                        clk,
   input  logic                        cptra_rst,
   input  logic [NUM_TIMERS-1:0]       tmr_en,
   input  logic [NUM_TIMERS-1:0]       tmr_cascade,
   input  logic [NUM_TIMERS-1:0]       tmr_restart,
   input  logic [NUM_TIMERS*CNT_W-1:0] tmr_period,
   input  logic [NUM_TIMERS*CNT_W-1:0] tmr_window,
   input  logic [PRESCALE_W-1:0]       prescale_div,
   input  logic [NUM_TIMERS-1:0]       tmr_serviced,
   output logic [NUM_TIMERS*CNT_W-1:0] tmr_count,
   output logic [NUM_TIMERS-1:0]       tmr_timeout,
   output logic [NUM_TIMERS-1:0]       tmr_early_restart,
   output logic                        fatal_timeout
);

   localparam int IDX_W = $clog2(NUM_TIMERS);

   logic [NUM_TIMERS-1:0][CNT_W-1:0] period_a;
   logic [NUM_TIMERS-1:0][CNT_W-1:0] window_a;
   logic [NUM_TIMERS-1:0][CNT_W-1:0] count_a;

   logic [NUM_TIMERS-1:0][IDX_W-1:0] head_idx;
   logic [NUM_TIMERS-1:0][IDX_W-1:0] tail_idx;
   logic [NUM_TIMERS-1:0]            is_head;
   logic [NUM_TIMERS-1:0]            is_tail;
   logic [NUM_TIMERS-1:0]            lock;
   logic [NUM_TIMERS-1:0]            svc_q;
   logic [NUM_TIMERS-1:0]            seg_clr;
   logic [NUM_TIMERS-1:0]            fatal_set;
   logic [NUM_TIMERS-1:0]            fatal_tail;

   logic [PRESCALE_W-1:0]            pre_cnt;
   logic                             tick;
   logic                             unused_cascade0;

   assign period_a  = tmr_period;
   assign window_a  = tmr_window;
   assign tmr_count = count_a;

   // timer 0 is always a head, so its cascade bit carries no meaning
   assign unused_cascade0 = tmr_cascade[0];

   // ------------------------------------------------------------------
   // prescaler: >= compare so lowering the divider mid-count ticks next cycle
   // ------------------------------------------------------------------
   assign tick = (pre_cnt >= prescale_div);

   // prescale counter wraps to zero on the tick edge
   always_ff @(posedge clk or posedge cptra_rst) begin
      if (cptra_rst)
         pre_cnt <= '0;
      else if (tick)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   // ------------------------------------------------------------------
   // segmentation: head/tail flags and, per timer, the index of its head and tail
   // ------------------------------------------------------------------
   assign is_head[0] = 1'b1;
   assign is_tail[NUM_TIMERS-1] = 1'b1;

   for (genvar g = 1; g < NUM_TIMERS; g++) begin : g_seg
      assign is_head[g]   = ~tmr_cascade[g];
      assign is_tail[g-1] = ~tmr_cascade[g];
   end

   // head of timer i: highest non-cascaded index <= i (last write wins)
   always_comb begin
      head_idx = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         for (int j = 1; j <= i; j++) begin
            if (!tmr_cascade[j])
               head_idx[i] = IDX_W'(j);
         end
      end
   end

   // tail of timer i: one below the lowest non-cascaded index > i, else the last timer
   always_comb begin
      tail_idx = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         tail_idx[i] = IDX_W'(NUM_TIMERS - 1);
         for (int j = NUM_TIMERS - 1; j > i; j--) begin
            if (!tmr_cascade[j])
               tail_idx[i] = IDX_W'(j - 1);
         end
      end
   end

   // ------------------------------------------------------------------
   // lock / service qualification
   // A multi-timer segment whose tail is timed out (or has latched fatal) is frozen:
   // only reset brings it back. Single-timer segments never lock.
   // ------------------------------------------------------------------
   always_comb begin
      lock    = '0;
      svc_q   = '0;
      seg_clr = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         lock[i] = fatal_tail[tail_idx[i]] |
                   ((tail_idx[i] != head_idx[i]) & tmr_timeout[tail_idx[i]]);
         svc_q[i] = is_head[i] & tmr_serviced[i] & tmr_timeout[i] & ~lock[i];
      end
      // a qualified service on the head clears every member, active or not
      for (int i = 0; i < NUM_TIMERS; i++)
         seg_clr[i] = svc_q[head_idx[i]];
   end

   // ------------------------------------------------------------------
   // per-timer counters
   // ------------------------------------------------------------------
   for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_tmr
      logic prev_to;

      if (g == 0) begin : g_first
         assign prev_to = 1'b0;
      end else begin : g_rest
         assign prev_to = tmr_timeout[g-1];
      end

      wdt_chain_tmr #(.CNT_W(CNT_W)) u_tmr (
         .clk          (clk),
         .cptra_rst    (cptra_rst),
         .tick         (tick),
         .is_head      (is_head[g]),
         .en           (tmr_en[g]),
         .prev_timeout (prev_to),
         .restart      (tmr_restart[g]),
         .seg_clr      (seg_clr[g]),
         .lock         (lock[g]),
         .period       (period_a[g]),
         .window       (window_a[g]),
         .count        (count_a[g]),
         .timeout      (tmr_timeout[g]),
         .early        (tmr_early_restart[g])
      );

      // a cascaded tail (so part of a multi-timer segment) that has expired is fatal
      if (g == 0) begin : g_nofatal
         assign fatal_set[g] = 1'b0;
      end else begin : g_fatal
         assign fatal_set[g] = tmr_cascade[g] & is_tail[g] & tmr_timeout[g];
      end
   end

   // ------------------------------------------------------------------
   // fatal: per-tail sticky record plus the aggregate output, both cleared only by reset
   // ------------------------------------------------------------------
   // per-tail fatal record keeps the segment locked even if its period is reprogrammed
   always_ff @(posedge clk or posedge cptra_rst) begin
      if (cptra_rst)
         fatal_tail <= '0;
      else
         fatal_tail <= fatal_tail | fatal_set;
   end

   // aggregate fatal, raised one cycle after a tail expires
   always_ff @(posedge clk or posedge cptra_rst) begin
      if (cptra_rst)
         fatal_timeout <= 1'b0;
      else if (|fatal_set)
         fatal_timeout <= 1'b1;
   end

endmodule

// File: tb/tb_wdt_chain.sv
// Bench for wdt_chain: directed scenarios followed by randomized episodes,
// all checked every cycle against a rule-level reference model.
module tb_wdt_chain;

   localparam int N  = 3;
   localparam int W  = 64;
   localparam int PW = 8;

   logic             clk = 1'b0;
   logic             cptra_rst;
   logic [N-1:0]     tmr_en, tmr_cascade, tmr_restart, tmr_serviced;
   logic [N*W-1:0]   tmr_period, tmr_window, tmr_count;
   logic [PW-1:0]    prescale_div;
   logic [N-1:0]     tmr_timeout, tmr_early_restart;
   logic             fatal_timeout;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [W-1:0]  m_cnt [N];
   logic [PW-1:0] m_pre;
   logic [N-1:0]  m_early;
   logic          m_fatal;

   wdt_chain #(.NUM_TIMERS(N), .CNT_W(W), .PRESCALE_W(PW)) dut (
      .clk               (clk),
      .cptra_rst         (cptra_rst),
      .tmr_en            (tmr_en),
      .tmr_cascade       (tmr_cascade),
      .tmr_restart       (tmr_restart),
      .tmr_period        (tmr_period),
      .tmr_window        (tmr_window),
      .prescale_div      (prescale_div),
      .tmr_serviced      (tmr_serviced),
      .tmr_count         (tmr_count),
      .tmr_timeout       (tmr_timeout),
      .tmr_early_restart (tmr_early_restart),
      .fatal_timeout     (fatal_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] per(input int i);
      return tmr_period[i*W +: W];
   endfunction

   function automatic logic [W-1:0] win(input int i);
      return tmr_window[i*W +: W];
   endfunction

   task automatic set_per(input int i, input logic [W-1:0] v);
      tmr_period[i*W +: W] = v;
   endtask

   task automatic set_win(input int i, input logic [W-1:0] v);
      tmr_window[i*W +: W] = v;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      m_pre   = '0;
      m_early = '0;
      m_fatal = 1'b0;
   endtask

   // one clock of the watchdog rules, using the inputs currently applied
   task automatic model_step();
      logic [N-1:0] to;
      logic [N-1:0] svc_ok;
      logic [N-1:0] act;
      logic [N-1:0] rs;
      logic         tick;
      int           hd [N];
      int           tl [N];
      logic [W-1:0] nx [N];

      tick = (m_pre >= prescale_div);
      for (int i = 0; i < N; i++) to[i] = (m_cnt[i] == per(i));
      for (int i = 0; i < N; i++) begin
         if (i == 0 || !tmr_cascade[i]) hd[i] = i;
         else hd[i] = hd[i-1];
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (i == N - 1) tl[i] = i;
         else if (!tmr_cascade[i+1]) tl[i] = i;
         else tl[i] = tl[i+1];
      end
      for (int h = 0; h < N; h++)
         svc_ok[h] = (hd[h] == h) && tmr_serviced[h] && to[h] && (tl[h] == h || !to[tl[h]]);
      for (int i = 0; i < N; i++) begin
         if (hd[i] == i) act[i] = tmr_en[i];
         else act[i] = to[i-1];
         rs[i] = (hd[i] == i) && act[i] && tmr_restart[i] && !to[i] && !(tl[i] != i && to[tl[i]]);
         if (rs[i] || svc_ok[hd[i]]) nx[i] = '0;
         else if (act[i] && tick && m_cnt[i] < per(i)) nx[i] = m_cnt[i] + 1;
         else nx[i] = m_cnt[i];
         if (rs[i] && win(i) != '0 && m_cnt[i] < win(i)) m_early[i] = 1'b1;
      end
      for (int i = 0; i < N; i++)
         if (hd[i] != i && tl[i] == i && to[i]) m_fatal = 1'b1;
      m_pre = tick ? '0 : m_pre + 1'b1;
      for (int i = 0; i < N; i++) m_cnt[i] = nx[i];
   endtask

   task automatic compare_all();
      logic [N*W-1:0] ec;
      logic [N-1:0]   et;
      for (int i = 0; i < N; i++) begin
         ec[i*W +: W] = m_cnt[i];
         et[i]        = (m_cnt[i] == per(i));
      end
      chk("count", tmr_count, ec);
      chk("timeout", tmr_timeout, et);
      chk("early", tmr_early_restart, m_early);
      chk("fatal", fatal_timeout, m_fatal);
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         model_step();
         @(posedge clk);
         #1;
         compare_all();
      end
   endtask

   task automatic do_reset();
      cptra_rst    = 1'b1;
      tmr_en       = '0;
      tmr_cascade  = '0;
      tmr_restart  = '0;
      tmr_serviced = '0;
      tmr_period   = '0;
      tmr_window   = '0;
      prescale_div = '0;
      @(posedge clk);
      #1;
      cptra_rst = 1'b0;
      model_reset();
   endtask

   initial begin
      // ---- reset state + independent timer timeout/service ----
      do_reset();
      compare_all();
      chk("rst_count", tmr_count, '0);
      chk("rst_fatal", fatal_timeout, 1'b0);
      set_per(0, 64'd5); set_per(1, 64'd20); set_per(2, 64'd20);
      tmr_en = 3'b111;
      step(5);
      chk("ind_count0_5", tmr_count[W-1:0], 64'd5);
      chk("ind_timeout0", tmr_timeout, 3'b001);
      step(2);
      chk("ind_hold0", tmr_count[W-1:0], 64'd5);
      tmr_serviced = 3'b001;
      step();
      tmr_serviced = '0;
      chk("ind_svc0", tmr_count[W-1:0], 64'd0);

      // ---- full cascade chain to fatal, then async reset ----
      do_reset();
      tmr_cascade = 3'b110;
      set_per(0, 64'd2); set_per(1, 64'd3); set_per(2, 64'd4);
      tmr_en = 3'b001;
      step(2);
      chk("chain_t0_out", tmr_timeout, 3'b001);
      step(3);
      chk("chain_t1_out", tmr_timeout, 3'b011);
      step(4);
      chk("chain_t2_out", tmr_timeout, 3'b111);
      chk("chain_nofatal_yet", fatal_timeout, 1'b0);
      step();
      chk("chain_fatal", fatal_timeout, 1'b1);
      tmr_serviced = 3'b001;
      step();
      tmr_serviced = '0;
      chk("chain_svc_ignored", tmr_count, {64'd4, 64'd3, 64'd2});
      #2 cptra_rst = 1'b1;
      #1;
      model_reset();
      chk("async_count", tmr_count, '0);
      chk("async_fatal", fatal_timeout, 1'b0);
      chk("async_early", tmr_early_restart, '0);
      @(posedge clk);
      #1 cptra_rst = 1'b0;

      // ---- chain service one cycle after head timeout ----
      do_reset();
      tmr_cascade = 3'b110;
      set_per(0, 64'd2); set_per(1, 64'd3); set_per(2, 64'd4);
      tmr_en = 3'b001;
      step(3);
      chk("svc_pre_counts", tmr_count, {64'd0, 64'd1, 64'd2});
      tmr_serviced = 3'b001;
      step();
      tmr_serviced = '0;
      chk("svc_counts_clr", tmr_count, '0);
      step(2);
      chk("svc_no_fatal", fatal_timeout, 1'b0);

      // ---- prescaler ----
      do_reset();
      prescale_div = 8'd3;
      set_per(0, 64'd2); set_per(1, 64'd50); set_per(2, 64'd50);
      tmr_en = 3'b001;
      step(3);
      chk("pre_c3", tmr_count[W-1:0], 64'd0);
      step();
      chk("pre_c4", tmr_count[W-1:0], 64'd1);
      step(4);
      chk("pre_c8", tmr_count[W-1:0], 64'd2);
      chk("pre_to8", tmr_timeout[0], 1'b1);

      // ---- window / early restart ----
      do_reset();
      set_per(0, 64'd20); set_per(1, 64'd20); set_per(2, 64'd20);
      set_win(0, 64'd10);
      tmr_en = 3'b001;
      step(4);
      tmr_restart = 3'b001;
      step();
      tmr_restart = '0;
      chk("win_clear", tmr_count[W-1:0], 64'd0);
      chk("win_early", tmr_early_restart, 3'b001);
      step(12);
      tmr_restart = 3'b001;
      step();
      tmr_restart = '0;
      chk("win_late_clear", tmr_count[W-1:0], 64'd0);
      chk("win_sticky", tmr_early_restart, 3'b001);

      // ---- randomized episodes ----
      for (int ep = 0; ep < 40; ep++) begin
         do_reset();
         tmr_cascade  = N'($urandom);
         prescale_div = PW'($urandom_range(0, 2));
         for (int i = 0; i < N; i++) begin
            set_per(i, W'($urandom_range(0, 9)));
            set_win(i, ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 8)));
         end
         for (int c = 0; c < 40; c++) begin
            tmr_en       = ($urandom_range(0, 3) != 0) ? 3'b111 : N'($urandom);
            tmr_restart  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            tmr_serviced = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) prescale_div = PW'($urandom_range(0, 3));
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
